// File: rtl/plcp_frame_parser.sv
// 802.11a PLCP receive-side frame parser: preamble hunt, SIGNAL decode and
// check, SERVICE strip, PSDU octet packing, tail/pad consumption.
module plcp_frame_parser #(
    parameter int unsigned                PREAMBLE_BITS    = 96,
    parameter logic [PREAMBLE_BITS-1:0]   PREAMBLE_PATTERN = {12{8'hAA}},
    parameter int unsigned                MAX_LENGTH       = 4095,
    parameter bit                         CHECK_RESERVED   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        bit_i,
    input  logic        bit_valid_i,
    output logic [7:0]  data_o,
    output logic        data_valid_o,
    output logic        frame_start_o,
    output logic        header_valid_o,
    output logic [3:0]  rate_o,
    output logic [11:0] length_o,
    output logic        frame_end_o,
    output logic        error_o,
    output logic [2:0]  error_code_o,
    output logic        busy_o
);

    typedef enum logic [3:0] {
        IDLE, SIG_RATE, SIG_RSVD, SIG_LEN, SIG_PAR, SIG_TAIL,
        SERVICE, PSDU, TAIL, PAD
    } state_e;

    state_e                   state_q, state_d;
    logic [14:0]              cnt_q, cnt_d, cnt_limit;
    logic [7:0]               sym_q, sym_d, sym_next, ndbps_q, ndbps_d;
    logic [PREAMBLE_BITS-1:0] hist_q, hist_d, hist_shift;
    logic [23:0]              sig_q, sig_d, sig_full;
    logic [7:0]               byte_q, byte_d, data_q, data_d;
    logic [3:0]               rate_q, rate_d, sig_rate;
    logic [11:0]              length_q, length_d, sig_len;
    logic [2:0]               code_q, code_d, sig_code;
    logic                     dv_q, dv_d, fs_q, fs_d, hv_q, hv_d;
    logic                     fe_q, fe_d, err_q, err_d;
    logic                     state_last, sym_wrap, preamble_hit, sig_last;

    // Data bits per OFDM symbol for each legal rate; 0 marks an illegal rate.
    function automatic logic [7:0] ndbps_of(input logic [3:0] r);
        unique case (r)
            4'b1101: return 8'd24;
            4'b1111: return 8'd36;
            4'b0101: return 8'd48;
            4'b0111: return 8'd72;
            4'b1001: return 8'd96;
            4'b1011: return 8'd144;
            4'b0001: return 8'd192;
            4'b0011: return 8'd216;
            default: return 8'd0;
        endcase
    endfunction

    // SIGNAL word as it stands once the current bit is included (bit 0 = first received).
    assign sig_full     = {bit_i, sig_q[23:1]};
    assign sig_rate     = {sig_full[0], sig_full[1], sig_full[2], sig_full[3]};
    assign sig_len      = sig_full[16:5];
    assign hist_shift   = {hist_q[PREAMBLE_BITS-2:0], bit_i};
    assign preamble_hit = (hist_shift == PREAMBLE_PATTERN);
    assign sym_next     = (sym_q == ndbps_q - 8'd1) ? 8'd0 : sym_q + 8'd1;
    assign sym_wrap     = (sym_next == 8'd0);
    assign state_last   = (cnt_q == cnt_limit);
    assign sig_last     = bit_valid_i && (state_q == SIG_TAIL) && state_last;

    // SIGNAL checks in priority order; 0 means the header is good.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        sig_code = 3'd0;
        if (ndbps_of(sig_rate) == 8'd0)                         sig_code = 3'd1;
        else if (CHECK_RESERVED && sig_full[4])                 sig_code = 3'd2;
        else if (sig_full[17] != ^sig_full[16:0])               sig_code = 3'd3;
        else if (|sig_full[23:18])                              sig_code = 3'd4;
        else if (sig_len == 12'd0 || 32'(sig_len) > MAX_LENGTH) sig_code = 3'd5;
    end

    // Last-bit count for each counted state.
    always_comb begin
        cnt_limit = '0;
        unique case (state_q)
            SIG_RATE: cnt_limit = 15'd3;
            SIG_LEN:  cnt_limit = 15'd11;
            SIG_TAIL: cnt_limit = 15'd5;
            SERVICE:  cnt_limit = 15'd15;
            PSDU:     cnt_limit = {length_q - 12'd1, 3'b111};
            TAIL:     cnt_limit = 15'd5;
            default:  cnt_limit = 15'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        else         state_q <= state_d;
    end

    // Next-state logic; nothing moves without a valid bit.
    always_comb begin
        state_d = state_q;
        if (bit_valid_i) begin
            unique case (state_q)
                IDLE:     if (preamble_hit) state_d = SIG_RATE;
                SIG_RATE: if (state_last)   state_d = SIG_RSVD;
                SIG_RSVD:                   state_d = SIG_LEN;
                SIG_LEN:  if (state_last)   state_d = SIG_PAR;
                SIG_PAR:                    state_d = SIG_TAIL;
                SIG_TAIL: if (state_last)   state_d = (sig_code == 3'd0) ? SERVICE : IDLE;
                SERVICE:  if (state_last)   state_d = PSDU;
                PSDU:     if (state_last)   state_d = TAIL;
                TAIL:     if (state_last)   state_d = sym_wrap ? IDLE : PAD;
                PAD:      if (sym_wrap)     state_d = IDLE;
                default:                    state_d = IDLE;
            endcase
        end
    end

    // Datapath next values: bit counter, symbol counter, history, SIGNAL and octet shifters.
    always_comb begin
        cnt_d   = cnt_q;
        sym_d   = sym_q;
        ndbps_d = ndbps_q;
        hist_d  = hist_q;
        sig_d   = sig_q;
        byte_d  = byte_q;
        if (bit_valid_i) begin
            cnt_d = (state_q == IDLE || state_d != state_q) ? 15'd0 : cnt_q + 15'd1;
            if (state_q == IDLE) hist_d = hist_shift;
            if (state_q inside {SIG_RATE, SIG_RSVD, SIG_LEN, SIG_PAR, SIG_TAIL}) sig_d = sig_full;
            if (state_q == PSDU) byte_d = {bit_i, byte_q[7:1]};
            if (state_q inside {SERVICE, PSDU, TAIL, PAD}) sym_d = sym_next;
            if (sig_last && sig_code == 3'd0) begin
                sym_d   = 8'd0;
                ndbps_d = ndbps_of(sig_rate);
            end
        end
        // A fresh hunt never sees bits from the frame just left.
        if (state_d == IDLE && state_q != IDLE) hist_d = '0;
    end

    // Output next values: one-cycle strobes plus held header/error fields.
    always_comb begin
        dv_d     = 1'b0;
        fs_d     = 1'b0;
        hv_d     = 1'b0;
        fe_d     = 1'b0;
        err_d    = 1'b0;
        data_d   = data_q;
        rate_d   = rate_q;
        length_d = length_q;
        code_d   = code_q;
        if (bit_valid_i) begin
            unique case (state_q)
                IDLE: fs_d = preamble_hit;
                SIG_TAIL: if (state_last) begin
                    if (sig_code == 3'd0) begin
                        hv_d     = 1'b1;
                        rate_d   = sig_rate;
                        length_d = sig_len;
                    end else begin
                        err_d  = 1'b1;
                        code_d = sig_code;
                    end
                end
                PSDU: if (cnt_q[2:0] == 3'b111) begin
                    dv_d   = 1'b1;
                    data_d = {bit_i, byte_q[7:1]};
                end
                TAIL:    fe_d = state_last && sym_wrap;
                PAD:     fe_d = sym_wrap;
                default: ;
            endcase
        end
    end

    // Datapath and output registers; the history is reset with everything else.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            sym_q    <= '0;
            ndbps_q  <= '0;
            hist_q   <= '0;
            sig_q    <= '0;
            byte_q   <= '0;
            data_q   <= '0;
            rate_q   <= '0;
            length_q <= '0;
            code_q   <= '0;
            dv_q     <= 1'b0;
            fs_q     <= 1'b0;
            hv_q     <= 1'b0;
            fe_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sym_q    <= sym_d;
            ndbps_q  <= ndbps_d;
            hist_q   <= hist_d;
            sig_q    <= sig_d;
            byte_q   <= byte_d;
            data_q   <= data_d;
            rate_q   <= rate_d;
            length_q <= length_d;
            code_q   <= code_d;
            dv_q     <= dv_d;
            fs_q     <= fs_d;
            hv_q     <= hv_d;
            fe_q     <= fe_d;
            err_q    <= err_d;
        end
    end

    assign data_o         = data_q;
    assign data_valid_o   = dv_q;
    assign frame_start_o  = fs_q;
    assign header_valid_o = hv_q;
    assign rate_o         = rate_q;
    assign length_o       = length_q;
    assign frame_end_o    = fe_q;
    assign error_o        = err_q;
    assign error_code_o   = code_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_plcp_frame_parser.sv
// Directed self-checking bench for plcp_frame_parser.
module tb_plcp_frame_parser;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        bit_i = 1'b0;
    logic        bit_valid_i = 1'b0;
    logic [7:0]  data_o;
    logic        data_valid_o, frame_start_o, header_valid_o;
    logic [3:0]  rate_o;
    logic [11:0] length_o;
    logic        frame_end_o, error_o;
    logic [2:0]  error_code_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    plcp_frame_parser dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .bit_i          (bit_i),
        .bit_valid_i    (bit_valid_i),
        .data_o         (data_o),
        .data_valid_o   (data_valid_o),
        .frame_start_o  (frame_start_o),
        .header_valid_o (header_valid_o),
        .rate_o         (rate_o),
        .length_o       (length_o),
        .frame_end_o    (frame_end_o),
        .error_o        (error_o),
        .error_code_o   (error_code_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor state
    int         n_valid = 0;
    int         dv_cnt, fs_cnt, hv_cnt, fe_cnt, err_cnt, bad_strobe;
    int         fs_at, dv_first_at, fe_at;
    logic [7:0] dv_q[$];
    logic [4:0] prev_strobes = '0;
    logic       frame_q[$];

    // Record strobes away from the active edge; flag any strobe held two cycles or illegal overlap.
    always @(negedge clk_i) begin
        if (data_valid_o) begin
            if (dv_cnt == 0) dv_first_at = n_valid;
            dv_q.push_back(data_o);
            dv_cnt++;
        end
        if (frame_start_o)  begin fs_cnt++; fs_at = n_valid; end
        if (header_valid_o) hv_cnt++;
        if (frame_end_o)    begin fe_cnt++; fe_at = n_valid; end
        if (error_o)        err_cnt++;
        if (({data_valid_o, frame_start_o, header_valid_o, frame_end_o, error_o} & prev_strobes) != 5'd0)
            bad_strobe++;
        if ((frame_end_o && data_valid_o) || (error_o && header_valid_o)) bad_strobe++;
        prev_strobes = {data_valid_o, frame_start_o, header_valid_o, frame_end_o, error_o};
    end

    task automatic clear_mon();
        dv_cnt = 0; fs_cnt = 0; hv_cnt = 0; fe_cnt = 0; err_cnt = 0; bad_strobe = 0;
        fs_at = -1; dv_first_at = -1; fe_at = -1; n_valid = 0;
        dv_q.delete();
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk_i);
        bit_i = b;
        bit_valid_i = 1'b1;
        @(posedge clk_i);
        n_valid++;
        #1 bit_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            bit_i = 1'($urandom_range(0, 1));
            bit_valid_i = 1'b0;
        end
    endtask

    task automatic send_bits(input int n, input bit gaps);
        for (int i = 0; i < n && frame_q.size() > 0; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            drive_bit(frame_q.pop_front());
        end
    endtask

    task automatic send_all(input bit gaps);
        send_bits(frame_q.size(), gaps);
        idle(4);
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) frame_q.push_back(v[i]);
    endtask

    task automatic push_preamble();
        logic [95:0] pat;
        pat = {12{8'hAA}};
        for (int i = 95; i >= 0; i--) frame_q.push_back(pat[i]);
    endtask

    task automatic push_signal(input logic [3:0] rate, input logic rsvd, input logic [11:0] len,
                               input logic flip_par, input logic [5:0] tail);
        for (int i = 3; i >= 0; i--) frame_q.push_back(rate[i]);
        frame_q.push_back(rsvd);
        push_bits({20'd0, len}, 12);
        frame_q.push_back((^rate) ^ rsvd ^ (^len) ^ flip_par);
        push_bits({26'd0, tail}, 6);
    endtask

    task automatic push_frame1();
        push_preamble();
        push_signal(4'b1101, 1'b0, 12'd1, 1'b0, 6'd0);
        push_bits(32'd0, 16);
        push_bits(32'h5A, 8);
        push_bits(32'd0, 6);
        push_bits(32'd0, 18);
    endtask

    task automatic push_frame2(input logic flip_par);
        push_preamble();
        push_signal(4'b0011, 1'b0, 12'd100, flip_par, 6'd0);
        push_bits(32'd0, 16);
        for (int b = 0; b < 100; b++) push_bits(32'(b), 8);
        push_bits(32'd0, 6);
        push_bits(32'd0, 42);
    endtask

    // Shared expectations for frame 1 (plain or with valid gaps).
    task automatic check_frame1(input string tag);
        checks++; if (fs_cnt !== 1 || fs_at !== 96) begin errors++;
            $display("FAIL %s frame_start: count=%0d at=%0d, want 1 at 96", tag, fs_cnt, fs_at); end
        checks++; if (hv_cnt !== 1) begin errors++;
            $display("FAIL %s header_valid: count=%0d, want 1", tag, hv_cnt); end
        checks++; if (rate_o !== 4'b1101 || length_o !== 12'd1) begin errors++;
            $display("FAIL %s header: rate=%b len=%0d, want 1101 1", tag, rate_o, length_o); end
        checks++; if (dv_cnt !== 1 || dv_q.size() != 1 || dv_q[0] !== 8'h5A) begin errors++;
            $display("FAIL %s data: count=%0d first=%h, want 1 5a", tag, dv_cnt,
                     (dv_q.size() > 0) ? dv_q[0] : 8'hxx); end
        checks++; if (dv_first_at !== 144) begin errors++;
            $display("FAIL %s data_latency: at=%0d, want 144", tag, dv_first_at); end
        checks++; if (fe_cnt !== 1 || fe_at !== 168) begin errors++;
            $display("FAIL %s frame_end: count=%0d at=%0d, want 1 at 168", tag, fe_cnt, fe_at); end
        checks++; if (err_cnt !== 0 || busy_o !== 1'b0) begin errors++;
            $display("FAIL %s idle_after: err=%0d busy=%b, want 0 0", tag, err_cnt, busy_o); end
        checks++; if (bad_strobe !== 0) begin errors++;
            $display("FAIL %s strobe_width: bad=%0d, want 0", tag, bad_strobe); end
    endtask

    task automatic test_reset();
        idle(3);
        checks++;
        if ({data_o, data_valid_o, frame_start_o, header_valid_o, rate_o, length_o,
             frame_end_o, error_o, error_code_o, busy_o} !== 33'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b rate=%b len=%0d code=%0d, want all 0",
                     busy_o, rate_o, length_o, error_code_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_basic();
        clear_mon();
        push_frame1();
        send_all(1'b0);
        check_frame1("basic");
    endtask

    task automatic test_long_frame();
        int bad;
        clear_mon();
        push_frame2(1'b0);
        send_all(1'b0);
        bad = 0;
        for (int i = 0; i < dv_q.size(); i++) if (dv_q[i] !== 8'(i)) bad++;
        checks++; if (dv_cnt !== 100 || bad !== 0) begin errors++;
            $display("FAIL long_data: count=%0d out_of_order=%0d, want 100 0", dv_cnt, bad); end
        checks++; if (rate_o !== 4'b0011 || length_o !== 12'd100) begin errors++;
            $display("FAIL long_header: rate=%b len=%0d, want 0011 100", rate_o, length_o); end
        checks++; if (fe_cnt !== 1 || fe_at !== 984) begin errors++;
            $display("FAIL long_frame_end: count=%0d at=%0d, want 1 at 984", fe_cnt, fe_at); end
        checks++; if (busy_o !== 1'b0 || bad_strobe !== 0) begin errors++;
            $display("FAIL long_after: busy=%b bad_strobe=%0d, want 0 0", busy_o, bad_strobe); end
    endtask

    task automatic test_parity_error();
        clear_mon();
        push_preamble();
        push_signal(4'b0011, 1'b0, 12'd100, 1'b1, 6'd0);
        push_bits(32'd0, 8);
        send_all(1'b0);
        checks++; if (err_cnt !== 1 || error_code_o !== 3'd3) begin errors++;
            $display("FAIL parity_error: count=%0d code=%0d, want 1 3", err_cnt, error_code_o); end
        checks++; if (hv_cnt !== 0 || busy_o !== 1'b0) begin errors++;
            $display("FAIL parity_noheader: hv=%0d busy=%b, want 0 0", hv_cnt, busy_o); end
        checks++; if (rate_o !== 4'b0011 || length_o !== 12'd100) begin errors++;
            $display("FAIL parity_hold: rate=%b len=%0d, want 0011 100", rate_o, length_o); end
        clear_mon();
        push_frame1();
        send_all(1'b0);
        check_frame1("after_error");
    endtask

    task automatic test_signal_errors();
        logic [3:0]  rates[5] = '{4'b0000, 4'b1101, 4'b0000, 4'b1101, 4'b1101};
        logic        rsvds[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [11:0] lens[5]  = '{12'd1, 12'd0, 12'd1, 12'd1, 12'd1};
        logic        flips[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [5:0]  tails[5] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'b000100};
        logic [2:0]  codes[5] = '{3'd1, 3'd5, 3'd1, 3'd2, 3'd4};
        for (int k = 0; k < 5; k++) begin
            clear_mon();
            push_preamble();
            push_signal(rates[k], rsvds[k], lens[k], flips[k], tails[k]);
            push_bits(32'd0, 8);
            send_all(1'b0);
            checks++;
            if (err_cnt !== 1 || error_code_o !== codes[k] || hv_cnt !== 0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL signal_error_%0d: err=%0d code=%0d hv=%0d busy=%b, want 1 %0d 0 0",
                         k, err_cnt, error_code_o, hv_cnt, busy_o, codes[k]);
            end
        end
    endtask

    task automatic test_valid_gaps();
        clear_mon();
        push_frame1();
        send_all(1'b1);
        check_frame1("gaps");
    endtask

    task automatic test_reset_mid();
        clear_mon();
        push_frame2(1'b0);
        send_bits(220, 1'b0);
        checks++; if (busy_o !== 1'b1 || dv_cnt !== 10) begin errors++;
            $display("FAIL mid_before_reset: busy=%b dv=%0d, want 1 10", busy_o, dv_cnt); end
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({data_o, data_valid_o, frame_start_o, header_valid_o, rate_o, length_o,
             frame_end_o, error_o, error_code_o, busy_o} !== 33'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b rate=%b len=%0d data=%h, want all 0",
                     busy_o, rate_o, length_o, data_o);
        end
        idle(2);
        rst_ni = 1'b1;
        clear_mon();
        send_all(1'b0);
        checks++; if (fs_cnt !== 0 || hv_cnt !== 0 || busy_o !== 1'b0) begin errors++;
            $display("FAIL leftover_bits: fs=%0d hv=%0d busy=%b, want 0 0 0", fs_cnt, hv_cnt, busy_o); end
        clear_mon();
        push_frame1();
        send_all(1'b0);
        check_frame1("post_reset");
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_long_frame();
        test_parity_error();
        test_signal_errors();
        test_valid_gaps();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/plcp_frame_parser.md
# plcp_frame_parser

Parametrised 802.11a PLCP receive-side frame parser. It hunts for a configurable preamble in a serial bit stream with a valid qualifier, then parses and fully checks the SIGNAL field. It strips SERVICE, emits PSDU octets, and consumes DATA tail and rate-dependent pad bits so the next frame is found on a clean boundary. It sits between the bit-level decode/descramble path and the MAC byte interface.

## Interface
- PREAMBLE_BITS, 96, preamble length in bits (≥8)
- PREAMBLE_PATTERN, {12{8'hAA}}, PREAMBLE_BITS-wide pattern; MSB = oldest bit
- MAX_LENGTH, 4095, largest accepted LENGTH (1..4095)
- CHECK_RESERVED, 1, 1 = reserved SIGNAL bit set is an error
- Clock  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Input  in  1  serial bit
- InputValid  in  1  Input is consumed only on cycles where this is 1
- Data  out  8  PSDU octet; first received bit → Data[0]
- DataValid  out  1  one-cycle strobe, Data valid
- FrameStart  out  1  one-cycle strobe, preamble matched
- HeaderValid  out  1  one-cycle strobe, SIGNAL passed all checks
- Rate  out  4  R1..R4, R1 → Rate[3]; held until next HeaderValid
- Length  out  12  LENGTH, first received bit → Length[0]; held as Rate
- FrameEnd  out  1  one-cycle strobe, last pad bit consumed
- Error  out  1  one-cycle strobe, frame aborted
- ErrorCode  out  3  reason, held until next Error
- Busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, SIG_RATE(4), SIG_RSVD(1), SIG_LEN(12), SIG_PAR(1), SIG_TAIL(6), SERVICE(16), PSDU(8·LENGTH), TAIL(6), PAD(0..N_DBPS−1). Bracketed values are valid-bit counts. All counters and transitions advance only on InputValid=1.
- IDLE: shift Input into a PREAMBLE_BITS history register. Leave IDLE when the history equals PREAMBLE_PATTERN. The history is cleared on every entry to IDLE and is not updated outside IDLE.
- SIGNAL checks run on the 24th SIGNAL bit. Priority order, first match wins:
  - Code 1: Rate not in {1101,1111,0101,0111,1001,1011,0001,0011}.
  - Code 2: reserved bit = 1 and CHECK_RESERVED = 1.
  - Code 3: parity bit ≠ XOR of the 17 preceding SIGNAL bits.
  - Code 4: any SIGNAL tail bit = 1.
  - Code 5: LENGTH = 0 or LENGTH > MAX_LENGTH.
- On any SIGNAL error: Error pulses, ErrorCode is set, go to IDLE. Rate and Length keep their previous values.
- N_DBPS by Rate: 1101→24, 1111→36, 0101→48, 0111→72, 1001→96, 1011→144, 0001→192, 0011→216.
- The symbol counter runs mod N_DBPS from the first SERVICE bit through PAD.
- SERVICE bits are discarded. PSDU bits are packed LSB-first, and DataValid pulses after each 8th bit.
- TAIL bits are consumed unchecked; this block sees descrambled data and the tail may be scrambled.
- After the 6th TAIL bit: if the symbol counter has wrapped to 0, FrameEnd fires with no PAD; otherwise stay in PAD until it wraps.
- FrameEnd always returns the block to IDLE.
- A preamble pattern appearing inside a frame is ignored.
- Counter widths: PSDU bit counter 15 bits; symbol counter 8 bits.

## Timing
- Reset low: every output is 0, state is IDLE, history is cleared. This applies immediately, including mid-frame. The first bit after reset release can be a history bit.
- All strobes are registered and appear the cycle after the qualifying valid input bit:
  - FrameStart: after the last preamble bit.
  - HeaderValid: after SIGNAL bit 24, in the same cycle Rate and Length update.
  - DataValid: after each 8th PSDU bit.
  - FrameEnd: after the final bit.
- Latency in valid bits: first DataValid comes 48 valid bits after FrameStart.
- InputValid = 0 freezes all state. Strobes still last exactly one cycle.
- The first valid bit after FrameEnd or Error is SIG-free history input (IDLE).
- Strobe exclusivity:
  - FrameEnd never coincides with DataValid: TAIL is at least 6 bits.
  - Error and HeaderValid are mutually exclusive.

## Test plan
- 96×'AA' pattern, then Rate 1101, reserved 0, LENGTH 1, parity 0, tail 0, SERVICE 0, PSDU 0x5A, 6 tail bits, 18 pad bits:
  - FrameStart, then HeaderValid with Rate=1101 and Length=1.
  - DataValid once with Data=0x5A.
  - FrameEnd exactly 48 valid bits after the first SERVICE bit.
- Rate 0011, LENGTH 100, parity 1, PSDU bytes 0..99: 100 DataValid in order, 42 pad bits consumed, FrameEnd, Busy low afterwards.
- Same frame with the parity bit flipped → Error, ErrorCode=3, no HeaderValid, back in IDLE. A following correct frame parses normally.
- Rate 0000, and separately LENGTH 0 → ErrorCode 1 and 5 respectively. Rate 0000 with a bad parity bit → ErrorCode 1 (priority).
- InputValid toggling 1-0-1 randomly across the whole of test 1 → identical Data, Rate and Length to test 1. Each strobe lasts one cycle.
- Reset pulsed low in mid-PSDU → all outputs 0 immediately. Leftover bits after release do not cause FrameStart. A fresh preamble does.
